// File: rtl/sp_types_pkg.sv
// Shared scratchpad types: instruction/response FIFO entries and response-stage state.
// Consumers import sp_types_pkg::*.
package sp_types_pkg;

    localparam int WORD_W       = 16;
    localparam int BITS_PER_ROW = 32;

    typedef struct packed {
        logic                    rw;
        logic [WORD_W-1:0]       addr;
        logic [BITS_PER_ROW-1:0] data;
    } instrFIFO_t;

    typedef struct packed {
        logic [BITS_PER_ROW-1:0] data;
    } rFIFO_t;

    typedef enum logic {
        RESP_EMPTY = 1'b0,
        RESP_FULL  = 1'b1
    } respState_t;

    // Loads carry no payload; zero it so the FIFO never sees stale store data.
    function automatic instrFIFO_t makeEntry(input logic rw,
                                             input logic [WORD_W-1:0] addr,
                                             input logic [BITS_PER_ROW-1:0] data);
        instrFIFO_t e;
        e.rw   = rw;
        e.addr = addr;
        e.data = rw ? data : '0;
        return e;
    endfunction

endpackage

// File: rtl/sp_resp_stage.sv
// One-entry load-response register between the response FIFO and the requester.
// Refills in the same cycle the held entry is consumed, so streaming has no bubbles.
module sp_resp_stage
    import sp_types_pkg::*;
(
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    rFIFO_empty,
    output logic                    rFIFO_REN,
    input  rFIFO_t                  rFIFO_rdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [BITS_PER_ROW-1:0] resp_data
);

    respState_t              stateReg;
    logic [BITS_PER_ROW-1:0] dataReg;

    assign rFIFO_REN  = !RST && !rFIFO_empty && ((stateReg == RESP_EMPTY) || resp_ready);
    assign resp_valid = !RST && (stateReg == RESP_FULL);
    assign resp_data  = dataReg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            stateReg <= RESP_EMPTY;
            dataReg  <= '0;
        end else begin
            case (stateReg)
                RESP_EMPTY: begin
                    if (rFIFO_REN) begin
                        stateReg <= RESP_FULL;
                        dataReg  <= rFIFO_rdata.data;
                    end
                end
                RESP_FULL: begin
                    if (resp_ready) begin
                        if (rFIFO_REN) begin
                            dataReg <= rFIFO_rdata.data;
                        end else begin
                            stateReg <= RESP_EMPTY;
                        end
                    end
                end
                default: stateReg <= RESP_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/sp_req_frontend.sv
// Scratchpad request frontend: issue register, outstanding-load credit and sticky error.
// Define SP_FRONTEND_STATS_EN to add saturating load/store counters (stat_loads, stat_stores).
module sp_req_frontend
    import sp_types_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
)
(
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [WORD_W-1:0]       req_addr,
    input  logic [BITS_PER_ROW-1:0] req_wdata,
    input  logic                    instrFIFO_full,
    output logic                    instrFIFO_WEN,
    output instrFIFO_t              instrFIFO_wdata,
    input  logic                    rFIFO_empty,
    output logic                    rFIFO_REN,
    input  rFIFO_t                  rFIFO_rdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [BITS_PER_ROW-1:0] resp_data,
    output logic                    err
`ifdef SP_FRONTEND_STATS_EN
    ,
    output logic [15:0]             stat_loads,
    output logic [15:0]             stat_stores
`endif
);

    logic       holdValidReg;
    instrFIFO_t holdEntryReg;
    logic [3:0] outstandingReg;
    logic       errReg;

    logic       issue;
    logic       loadIssue;
    logic       pendingLoad;
    logic [4:0] inFlight;
    logic       loadRoom;
    logic       accept;
    logic       respDone;

    assign issue       = !RST && holdValidReg && !instrFIFO_full;
    assign loadIssue   = issue && !holdEntryReg.rw;
    assign pendingLoad = holdValidReg && !holdEntryReg.rw;

    // A held load already owns a credit even though it has not reached the FIFO yet.
    assign inFlight    = {1'b0, outstandingReg} + {4'd0, pendingLoad};
    assign loadRoom    = inFlight < 5'(MAX_OUTSTANDING);

    assign req_ready       = !RST && (!holdValidReg || issue) && (req_write || loadRoom);
    assign accept          = req_valid && req_ready;
    assign instrFIFO_WEN   = issue;
    assign instrFIFO_wdata = holdEntryReg;
    assign respDone        = resp_valid && resp_ready;
    assign err             = errReg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            holdValidReg   <= 1'b0;
            holdEntryReg   <= '0;
            outstandingReg <= '0;
            errReg         <= 1'b0;
        end else begin
            if (accept) begin
                holdValidReg <= 1'b1;
                holdEntryReg <= makeEntry(req_write, req_addr, req_wdata);
            end else if (issue) begin
                holdValidReg <= 1'b0;
            end

            // Decrement is guarded so a stray response cannot wrap the credit counter.
            case ({loadIssue, respDone})
                2'b10:   outstandingReg <= outstandingReg + 4'd1;
                2'b01:   if (outstandingReg != 4'd0) outstandingReg <= outstandingReg - 4'd1;
                default: outstandingReg <= outstandingReg;
            endcase

            if (rFIFO_REN && (outstandingReg == 4'd0) && !loadIssue) begin
                errReg <= 1'b1;
            end
        end
    end

    sp_resp_stage u_resp_stage (
        .CLK         (CLK),
        .RST         (RST),
        .rFIFO_empty (rFIFO_empty),
        .rFIFO_REN   (rFIFO_REN),
        .rFIFO_rdata (rFIFO_rdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data)
    );

`ifdef SP_FRONTEND_STATS_EN
    logic [15:0] statVec [2];

    // Index 0 counts loads, index 1 counts stores.
    for (genvar gi = 0; gi < 2; gi++) begin : g_stat
        logic [15:0] cntReg;
        logic        hit;

        assign hit         = issue && (holdEntryReg.rw == (gi == 1));
        assign statVec[gi] = cntReg;

        always_ff @(posedge CLK) begin
            if (RST) begin
                cntReg <= '0;
            end else if (hit && (cntReg != 16'hFFFF)) begin
                cntReg <= cntReg + 16'd1;
            end
        end
    end

    assign stat_loads  = statVec[0];
    assign stat_stores = statVec[1];
`endif

endmodule

// File: tb/tb_sp_req_frontend.sv
// Directed bench for sp_req_frontend; response FIFO modelled as a small ring driven by the bench.
// Inputs change just after the falling edge, outputs are sampled 1 time unit later.
module tb_sp_req_frontend;
    import sp_types_pkg::*;

    logic                    CLK = 1'b0;
    logic                    RST;
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [WORD_W-1:0]       req_addr;
    logic [BITS_PER_ROW-1:0] req_wdata;
    logic                    instrFIFO_full;
    logic                    instrFIFO_WEN;
    instrFIFO_t              instrFIFO_wdata;
    logic                    rFIFO_empty;
    logic                    rFIFO_REN;
    rFIFO_t                  rFIFO_rdata;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [BITS_PER_ROW-1:0] resp_data;
    logic                    err;
`ifdef SP_FRONTEND_STATS_EN
    logic [15:0]             stat_loads;
    logic [15:0]             stat_stores;
`endif

    int vecCount = 0;
    int missCount = 0;

    logic [31:0] rqMem [0:15];
    int rqHead = 0;
    int rqTail = 0;

    always #5 CLK = ~CLK;

    assign rFIFO_empty = (rqHead == rqTail);
    assign rFIFO_rdata = rqMem[rqHead & 15];

    always @(posedge CLK) begin
        if (rFIFO_REN && (rqHead != rqTail)) rqHead <= rqHead + 1;
    end

    sp_req_frontend #(.MAX_OUTSTANDING(4)) dut (
        .CLK             (CLK),
        .RST             (RST),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .instrFIFO_full  (instrFIFO_full),
        .instrFIFO_WEN   (instrFIFO_WEN),
        .instrFIFO_wdata (instrFIFO_wdata),
        .rFIFO_empty     (rFIFO_empty),
        .rFIFO_REN       (rFIFO_REN),
        .rFIFO_rdata     (rFIFO_rdata),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_data       (resp_data),
        .err             (err)
`ifdef SP_FRONTEND_STATS_EN
        ,
        .stat_loads      (stat_loads),
        .stat_stores     (stat_stores)
`endif
    );

    task automatic pushResp(input logic [31:0] v);
        rqMem[rqTail & 15] = v;
        rqTail = rqTail + 1;
    endtask

    task automatic test_reset;
        RST = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h99; req_wdata = 32'h1;
        instrFIFO_full = 1'b0; resp_ready = 1'b0;
        @(negedge CLK); #1;
        vecCount++; if (req_ready !== 1'b0) begin missCount++; $display("FAIL rst_ready got %b want 0", req_ready); end
        vecCount++; if (instrFIFO_WEN !== 1'b0) begin missCount++; $display("FAIL rst_wen got %b want 0", instrFIFO_WEN); end
        vecCount++; if (rFIFO_REN !== 1'b0) begin missCount++; $display("FAIL rst_ren got %b want 0", rFIFO_REN); end
        vecCount++; if (resp_valid !== 1'b0) begin missCount++; $display("FAIL rst_rvalid got %b want 0", resp_valid); end
        @(negedge CLK); #1;
        vecCount++; if (instrFIFO_wdata !== '0) begin missCount++; $display("FAIL rst_wdata got %h want 0", instrFIFO_wdata); end
        vecCount++; if (resp_data !== '0) begin missCount++; $display("FAIL rst_rdata got %h want 0", resp_data); end
        vecCount++; if (err !== 1'b0) begin missCount++; $display("FAIL rst_err got %b want 0", err); end
        vecCount++; if (dut.outstandingReg !== 4'd0) begin missCount++; $display("FAIL rst_outst got %0d want 0", dut.outstandingReg); end
        @(negedge CLK);
        RST = 1'b0; req_valid = 1'b0;
        #1;
        vecCount++; if (instrFIFO_WEN !== 1'b0) begin missCount++; $display("FAIL rst_release_wen got %b want 0", instrFIFO_WEN); end
        $display("test_reset done");
    endtask

    task automatic test_load_issue;
        @(negedge CLK);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h10; req_wdata = 32'hDEADBEEF;
        #1;
        vecCount++; if (req_ready !== 1'b1) begin missCount++; $display("FAIL load_ready got %b want 1", req_ready); end
        vecCount++; if (instrFIFO_WEN !== 1'b0) begin missCount++; $display("FAIL load_wen_early got %b want 0", instrFIFO_WEN); end
        @(negedge CLK);
        req_valid = 1'b0;
        #1;
        vecCount++; if (instrFIFO_WEN !== 1'b1) begin missCount++; $display("FAIL load_wen got %b want 1", instrFIFO_WEN); end
        vecCount++; if (instrFIFO_wdata !== {1'b0, 16'h0010, 32'h0}) begin missCount++; $display("FAIL load_entry got %h want %h", instrFIFO_wdata, {1'b0, 16'h0010, 32'h0}); end
        @(negedge CLK); #1;
        vecCount++; if (instrFIFO_WEN !== 1'b0) begin missCount++; $display("FAIL load_wen_once got %b want 0", instrFIFO_WEN); end
        vecCount++; if (dut.outstandingReg !== 4'd1) begin missCount++; $display("FAIL load_outst got %0d want 1", dut.outstandingReg); end
        $display("test_load_issue done");
    endtask

    task automatic test_full_stall;
        instrFIFO_t exp1;
        exp1 = {1'b1, 16'h0022, 32'h12345678};
        @(negedge CLK);
        instrFIFO_full = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h22; req_wdata = 32'h12345678;
        #1;
        vecCount++; if (req_ready !== 1'b1) begin missCount++; $display("FAIL full_first_ready got %b want 1", req_ready); end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            req_addr = 16'h33; req_wdata = 32'h0BADF00D;
            #1;
            vecCount++; if (instrFIFO_WEN !== 1'b0) begin missCount++; $display("FAIL full_wen[%0d] got %b want 0", i, instrFIFO_WEN); end
            vecCount++; if (req_ready !== 1'b0) begin missCount++; $display("FAIL full_ready[%0d] got %b want 0", i, req_ready); end
            vecCount++; if (instrFIFO_wdata !== exp1) begin missCount++; $display("FAIL full_entry[%0d] got %h want %h", i, instrFIFO_wdata, exp1); end
        end
        @(negedge CLK);
        instrFIFO_full = 1'b0;
        #1;
        vecCount++; if (instrFIFO_WEN !== 1'b1) begin missCount++; $display("FAIL full_drop_wen got %b want 1", instrFIFO_WEN); end
        vecCount++; if (instrFIFO_wdata !== exp1) begin missCount++; $display("FAIL full_drop_entry got %h want %h", instrFIFO_wdata, exp1); end
        vecCount++; if (req_ready !== 1'b1) begin missCount++; $display("FAIL full_drop_ready got %b want 1", req_ready); end
        @(negedge CLK);
        req_valid = 1'b0;
        #1;
        vecCount++; if (instrFIFO_WEN !== 1'b1) begin missCount++; $display("FAIL full_second_wen got %b want 1", instrFIFO_WEN); end
        vecCount++; if (instrFIFO_wdata.addr !== 16'h33) begin missCount++; $display("FAIL full_second_addr got %h want 0033", instrFIFO_wdata.addr); end
        @(negedge CLK); #1;
        vecCount++; if (instrFIFO_WEN !== 1'b0) begin missCount++; $display("FAIL full_no_dup got %b want 0", instrFIFO_WEN); end
        vecCount++; if (dut.outstandingReg !== 4'd1) begin missCount++; $display("FAIL full_outst got %0d want 1", dut.outstandingReg); end
        $display("test_full_stall done");
    endtask

    task automatic test_max_outstanding;
        logic [3:0] expReady;
        expReady = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h40 + 16'(i);
            #1;
            vecCount++; if (req_ready !== expReady[i]) begin missCount++; $display("FAIL max_ready[%0d] got %b want %b", i, req_ready, expReady[i]); end
        end
        @(negedge CLK); #1;
        vecCount++; if (req_ready !== 1'b0) begin missCount++; $display("FAIL max_fifth_ready got %b want 0", req_ready); end
        vecCount++; if (dut.outstandingReg !== 4'd4) begin missCount++; $display("FAIL max_outst got %0d want 4", dut.outstandingReg); end
        @(negedge CLK);
        req_write = 1'b1; req_addr = 16'h60; req_wdata = 32'h5;
        #1;
        vecCount++; if (req_ready !== 1'b1) begin missCount++; $display("FAIL max_store_ready got %b want 1", req_ready); end
        @(negedge CLK);
        req_write = 1'b0; req_addr = 16'h50; resp_ready = 1'b1;
        pushResp(32'hA0);
        #1;
        vecCount++; if (instrFIFO_WEN !== 1'b1) begin missCount++; $display("FAIL max_store_wen got %b want 1", instrFIFO_WEN); end
        vecCount++; if (req_ready !== 1'b0) begin missCount++; $display("FAIL max_blocked_ready got %b want 0", req_ready); end
        vecCount++; if (rFIFO_REN !== 1'b1) begin missCount++; $display("FAIL max_ren got %b want 1", rFIFO_REN); end
        @(negedge CLK); #1;
        vecCount++; if (resp_valid !== 1'b1) begin missCount++; $display("FAIL max_rvalid got %b want 1", resp_valid); end
        vecCount++; if (resp_data !== 32'hA0) begin missCount++; $display("FAIL max_rdata got %h want 000000a0", resp_data); end
        vecCount++; if (req_ready !== 1'b0) begin missCount++; $display("FAIL max_pre_ret_ready got %b want 0", req_ready); end
        @(negedge CLK); #1;
        vecCount++; if (req_ready !== 1'b1) begin missCount++; $display("FAIL max_post_ret_ready got %b want 1", req_ready); end
        @(negedge CLK);
        req_valid = 1'b0;
        #1;
        vecCount++; if (instrFIFO_WEN !== 1'b1) begin missCount++; $display("FAIL max_fifth_wen got %b want 1", instrFIFO_WEN); end
        vecCount++; if (instrFIFO_wdata.addr !== 16'h50) begin missCount++; $display("FAIL max_fifth_addr got %h want 0050", instrFIFO_wdata.addr); end
        $display("test_max_outstanding done");
    endtask

    task automatic test_back_to_back;
        @(negedge CLK);
        resp_ready = 1'b0;
        pushResp(32'hA); pushResp(32'hB);
        #1;
        vecCount++; if (dut.outstandingReg !== 4'd4) begin missCount++; $display("FAIL b2b_outst_start got %0d want 4", dut.outstandingReg); end
        vecCount++; if (rFIFO_REN !== 1'b1) begin missCount++; $display("FAIL b2b_first_ren got %b want 1", rFIFO_REN); end
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK); #1;
            vecCount++; if (rFIFO_REN !== 1'b0) begin missCount++; $display("FAIL b2b_hold_ren[%0d] got %b want 0", i, rFIFO_REN); end
            vecCount++; if (resp_data !== 32'hA || resp_valid !== 1'b1) begin missCount++; $display("FAIL b2b_hold[%0d] got v=%b d=%h want v=1 d=0000000a", i, resp_valid, resp_data); end
        end
        @(negedge CLK);
        resp_ready = 1'b1;
        #1;
        vecCount++; if (rFIFO_REN !== 1'b1) begin missCount++; $display("FAIL b2b_refill_ren got %b want 1", rFIFO_REN); end
        vecCount++; if (resp_data !== 32'hA) begin missCount++; $display("FAIL b2b_first_data got %h want 0000000a", resp_data); end
        @(negedge CLK); #1;
        vecCount++; if (resp_valid !== 1'b1 || resp_data !== 32'hB) begin missCount++; $display("FAIL b2b_second got v=%b d=%h want v=1 d=0000000b", resp_valid, resp_data); end
        vecCount++; if (rFIFO_REN !== 1'b0) begin missCount++; $display("FAIL b2b_empty_ren got %b want 0", rFIFO_REN); end
        @(negedge CLK);
        resp_ready = 1'b0;
        #1;
        vecCount++; if (resp_valid !== 1'b0) begin missCount++; $display("FAIL b2b_done_valid got %b want 0", resp_valid); end
        vecCount++; if (dut.outstandingReg !== 4'd2) begin missCount++; $display("FAIL b2b_outst got %0d want 2", dut.outstandingReg); end
        $display("test_back_to_back done");
    endtask

    task automatic test_err;
        @(negedge CLK);
        resp_ready = 1'b1;
        pushResp(32'hC); pushResp(32'hD);
        repeat (3) @(negedge CLK);
        resp_ready = 1'b0;
        #1;
        vecCount++; if (dut.outstandingReg !== 4'd0) begin missCount++; $display("FAIL err_drain_outst got %0d want 0", dut.outstandingReg); end
        vecCount++; if (err !== 1'b0) begin missCount++; $display("FAIL err_clean got %b want 0", err); end
        pushResp(32'hE);
        #1;
        vecCount++; if (rFIFO_REN !== 1'b1) begin missCount++; $display("FAIL err_ren got %b want 1", rFIFO_REN); end
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK); #1;
            vecCount++; if (err !== 1'b1) begin missCount++; $display("FAIL err_sticky[%0d] got %b want 1", i, err); end
        end
        vecCount++; if (resp_valid !== 1'b1 || resp_data !== 32'hE) begin missCount++; $display("FAIL err_resp got v=%b d=%h want v=1 d=0000000e", resp_valid, resp_data); end
        $display("test_err done");
    endtask

    task automatic test_reset_midop;
        @(negedge CLK);
        instrFIFO_full = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h77; req_wdata = 32'h77;
        #1;
        vecCount++; if (req_ready !== 1'b1) begin missCount++; $display("FAIL mid_ready got %b want 1", req_ready); end
        @(negedge CLK);
        req_valid = 1'b0; RST = 1'b1;
        #1;
        vecCount++; if (instrFIFO_WEN !== 1'b0 || rFIFO_REN !== 1'b0) begin missCount++; $display("FAIL mid_rst_strobes got wen=%b ren=%b want 0 0", instrFIFO_WEN, rFIFO_REN); end
        vecCount++; if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin missCount++; $display("FAIL mid_rst_hs got rv=%b rr=%b want 0 0", resp_valid, req_ready); end
        @(negedge CLK);
        RST = 1'b0; instrFIFO_full = 1'b0;
        #1;
        vecCount++; if (err !== 1'b0) begin missCount++; $display("FAIL mid_err got %b want 0", err); end
        vecCount++; if (resp_valid !== 1'b0 || resp_data !== '0) begin missCount++; $display("FAIL mid_resp got v=%b d=%h want 0 0", resp_valid, resp_data); end
        vecCount++; if (instrFIFO_wdata !== '0) begin missCount++; $display("FAIL mid_wdata got %h want 0", instrFIFO_wdata); end
        vecCount++; if (dut.outstandingReg !== 4'd0) begin missCount++; $display("FAIL mid_outst got %0d want 0", dut.outstandingReg); end
        for (int i = 0; i < 4; i++) begin
            vecCount++; if (instrFIFO_WEN !== 1'b0) begin missCount++; $display("FAIL mid_no_wen[%0d] got %b want 0", i, instrFIFO_WEN); end
            @(negedge CLK); #1;
        end
        $display("test_reset_midop done");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_issue();
        test_full_stall();
        test_max_outstanding();
        test_back_to_back();
        test_err();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
